// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic [5:0] PRESC_8  = 6'd8;
  localparam logic [5:0] PRESC_16 = 6'd16;
  localparam logic [5:0] PRESC_32 = 6'd32;

  // Any oversampling ratio other than 16 or 32 runs at 8.
  function automatic logic [5:0] legal_prescale(input logic [5:0] p);
    case (p)
      PRESC_16, PRESC_32: return p;
      default:            return PRESC_8;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and 3-sample majority voter around mid-bit.
module uart_rx_sampler (
  input  logic       CLK,
  input  logic       RST,
  input  logic       clr_i,
  input  logic [5:0] prescale_i,
  input  logic       rx_i,
  output logic [5:0] edge_cnt_o,
  output logic       bit_end_o,
  output logic       sampled_bit_o,
  output logic       sample_done_o
);

  logic [5:0] edge_cnt_q, edge_cnt_d;
  logic [2:0] smp_q;
  logic [5:0] half;

  assign half          = prescale_i >> 1;
  assign edge_cnt_o    = edge_cnt_q;
  assign bit_end_o     = (edge_cnt_q == prescale_i - 6'd1);
  assign sample_done_o = (edge_cnt_q == half + 6'd2);
  assign sampled_bit_o = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);

  always_comb begin
    edge_cnt_d = edge_cnt_q + 6'd1;
    if (clr_i || bit_end_o) edge_cnt_d = '0;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt_q <= '0;
      smp_q      <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      if (edge_cnt_q == half - 6'd1) smp_q[0] <= rx_i;
      if (edge_cnt_q == half)        smp_q[1] <= rx_i;
      if (edge_cnt_q == half + 6'd1) smp_q[2] <= rx_i;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: frame FSM, data shift register, parity/stop checks, registered outputs.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  stop_error
);

  localparam int unsigned BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  rx_state_e             state_q, state_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
  logic [5:0]            presc_q, presc_d;
  logic                  pen_q, pen_d;
  logic                  ptyp_q, ptyp_d;
  logic                  par_err_q, par_err_d;
  logic                  dv_q, dv_d;
  logic                  pe_q, pe_d;
  logic                  se_q, se_d;

  logic [5:0] edge_cnt_unused;
  logic       bit_end, sampled_bit, sample_done;

  // Counter clears whenever the next cycle is IDLE, so a new start edge always begins at 0.
  uart_rx_sampler u_sampler (
    .CLK           (CLK),
    .RST           (RST),
    .clr_i         (state_d == ST_IDLE),
    .prescale_i    (presc_q),
    .rx_i          (RX_IN),
    .edge_cnt_o    (edge_cnt_unused),
    .bit_end_o     (bit_end),
    .sampled_bit_o (sampled_bit),
    .sample_done_o (sample_done)
  );

  assign P_DATA       = pdata_q;
  assign data_valid   = dv_q;
  assign parity_error = pe_q;
  assign stop_error   = se_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    pdata_d   = pdata_q;
    presc_d   = presc_q;
    pen_d     = pen_q;
    ptyp_d    = ptyp_q;
    par_err_d = par_err_q;
    dv_d      = 1'b0;
    pe_d      = 1'b0;
    se_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!RX_IN) begin
          state_d   = ST_START;
          presc_d   = legal_prescale(Prescale);
          pen_d     = PAR_EN;
          ptyp_d    = PAR_TYP;
          par_err_d = 1'b0;
          bit_cnt_d = '0;
        end
      end
      ST_START: begin
        if (sample_done && sampled_bit) begin
          state_d = ST_IDLE;
        end else if (bit_end) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
          if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
            state_d   = pen_q ? ST_PARITY : ST_STOP;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          if (sampled_bit != ((^shift_q) ^ ptyp_q)) par_err_d = 1'b1;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          state_d = ST_IDLE;
          if (par_err_q || !sampled_bit) begin
            pe_d = par_err_q;
            se_d = !sampled_bit;
          end else begin
            dv_d    = 1'b1;
            pdata_d = shift_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      pdata_q   <= '0;
      presc_q   <= PRESC_8;
      pen_q     <= 1'b0;
      ptyp_q    <= PAR_EVEN;
      par_err_q <= 1'b0;
      dv_q      <= 1'b0;
      pe_q      <= 1'b0;
      se_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      pdata_q   <= pdata_d;
      presc_q   <= presc_d;
      pen_q     <= pen_d;
      ptyp_q    <= ptyp_d;
      par_err_q <= par_err_d;
      dv_q      <= dv_d;
      pe_q      <= pe_d;
      se_q      <= se_d;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames, glitches, errors, back-to-back and mid-frame reset.
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       parity_error;
  logic       stop_error;

  uart_rx #(.DATA_WIDTH(8)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_IN        (RX_IN),
    .PAR_EN       (PAR_EN),
    .PAR_TYP      (PAR_TYP),
    .Prescale     (Prescale),
    .P_DATA       (P_DATA),
    .data_valid   (data_valid),
    .parity_error (parity_error),
    .stop_error   (stop_error)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int         dv_cyc_q[$];
  logic [7:0] dv_dat_q[$];
  int         pe_cnt = 0;
  int         se_cnt = 0;
  int         se_cyc = 0;

  always @(negedge CLK) begin
    if (data_valid) begin
      dv_cyc_q.push_back(cyc);
      dv_dat_q.push_back(P_DATA);
    end
    if (parity_error) pe_cnt = pe_cnt + 1;
    if (stop_error) begin
      se_cnt = se_cnt + 1;
      se_cyc = cyc;
    end
  end

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int t0, t0b;
  int dv0, pe0, se0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic snap();
    dv0 = dv_cyc_q.size();
    pe0 = pe_cnt;
    se0 = se_cnt;
  endtask

  // Called #1 after a posedge; the first bit cycle is edge 0 of the start bit.
  task automatic send_frame(input int p, input logic [7:0] d, input logic pen, input logic ptyp,
                            input logic pbit, input logic sbit, input int gbit, input int gedge);
    logic [10:0] bits;
    int nb;
    Prescale = 6'(p);
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    bits     = '1;
    bits[0]  = 1'b0;
    bits[8:1] = d;
    if (pen) begin
      bits[9]  = pbit;
      bits[10] = sbit;
      nb = 11;
    end else begin
      bits[9] = sbit;
      nb = 10;
    end
    t0 = cyc;
    for (int i = 0; i < nb; i++) begin
      for (int e = 0; e < p; e++) begin
        RX_IN = bits[i] ^ ((i == gbit) && (e == gedge));
        @(posedge CLK);
        #1;
      end
    end
    RX_IN = 1'b1;
  endtask

  initial begin
    RST = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd8;
    idle(3);
    chk("reset_dv", 32'(data_valid), 32'h0);
    chk("reset_pe", 32'(parity_error), 32'h0);
    chk("reset_se", 32'(stop_error), 32'h0);
    chk("reset_pdata", 32'(P_DATA), 32'h0);
    RST = 1'b1;
    idle(5);

    // 1: P=8, even parity, 0xA5 (four ones -> parity 0)
    snap();
    send_frame(8, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, -1, 0);
    idle(4);
    chk("t1_dv_count", 32'(dv_cyc_q.size() - dv0), 32'd1);
    chk("t1_latency", 32'(dv_cyc_q[dv0] - t0), 32'd88);
    chk("t1_data", 32'(dv_dat_q[dv0]), 32'hA5);
    chk("t1_pe", 32'(pe_cnt - pe0), 32'd0);
    chk("t1_se", 32'(se_cnt - se0), 32'd0);

    // 2: 2-cycle start glitch, then a real frame
    snap();
    RX_IN = 1'b0;
    idle(2);
    RX_IN = 1'b1;
    idle(20);
    chk("t2_glitch_dv", 32'(dv_cyc_q.size() - dv0), 32'd0);
    chk("t2_glitch_pe", 32'(pe_cnt - pe0), 32'd0);
    chk("t2_glitch_se", 32'(se_cnt - se0), 32'd0);
    send_frame(8, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0);
    idle(4);
    chk("t2_dv_count", 32'(dv_cyc_q.size() - dv0), 32'd1);
    chk("t2_data", 32'(dv_dat_q[dv0]), 32'h5A);
    chk("t2_latency", 32'(dv_cyc_q[dv0] - t0), 32'd80);

    // 3: P=16, odd parity, 0x3C needs parity 1; send 0
    snap();
    send_frame(16, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, -1, 0);
    idle(4);
    chk("t3_pe", 32'(pe_cnt - pe0), 32'd1);
    chk("t3_dv", 32'(dv_cyc_q.size() - dv0), 32'd0);
    chk("t3_se", 32'(se_cnt - se0), 32'd0);
    chk("t3_pdata_kept", 32'(P_DATA), 32'h5A);

    // 4: P=16, no parity, 0x81 with stop bit 0
    snap();
    send_frame(16, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0);
    idle(4);
    chk("t4_se", 32'(se_cnt - se0), 32'd1);
    chk("t4_se_cycle", 32'(se_cyc - t0), 32'd160);
    chk("t4_dv", 32'(dv_cyc_q.size() - dv0), 32'd0);
    chk("t4_pdata_kept", 32'(P_DATA), 32'h5A);

    // 5: P=32 back-to-back 0x00 then 0xFF
    snap();
    send_frame(32, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0);
    t0b = t0;
    send_frame(32, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0);
    idle(4);
    chk("t5_dv_count", 32'(dv_cyc_q.size() - dv0), 32'd2);
    chk("t5_first_lat", 32'(dv_cyc_q[dv0] - t0b), 32'd320);
    chk("t5_spacing", 32'(dv_cyc_q[dv0+1] - dv_cyc_q[dv0]), 32'd320);
    chk("t5_data0", 32'(dv_dat_q[dv0]), 32'h00);
    chk("t5_data1", 32'(dv_dat_q[dv0+1]), 32'hFF);
    chk("t5_errs", 32'((pe_cnt - pe0) + (se_cnt - se0)), 32'd0);

    // single-cycle glitches: non-sampling edge 2, then sample edge P/2
    snap();
    send_frame(16, 8'h96, 1'b0, 1'b0, 1'b0, 1'b1, 3, 2);
    idle(4);
    send_frame(16, 8'h69, 1'b0, 1'b0, 1'b0, 1'b1, 5, 8);
    idle(4);
    chk("glitch_dv_count", 32'(dv_cyc_q.size() - dv0), 32'd2);
    chk("glitch_nonsample", 32'(dv_dat_q[dv0]), 32'h96);
    chk("glitch_sample", 32'(dv_dat_q[dv0+1]), 32'h69);

    // 6: reset during data bit 4
    snap();
    Prescale = 6'd8; PAR_EN = 1'b0;
    RX_IN = 1'b0;
    idle(8);
    RX_IN = 1'b1;
    idle(8 * 4 + 3);
    RST = 1'b0;
    #1;
    chk("t6_rst_dv", 32'(data_valid), 32'h0);
    chk("t6_rst_pe", 32'(parity_error), 32'h0);
    chk("t6_rst_se", 32'(stop_error), 32'h0);
    chk("t6_rst_pdata", 32'(P_DATA), 32'h0);
    idle(3);
    RST = 1'b1;
    idle(100);
    chk("t6_no_pulse", 32'((dv_cyc_q.size() - dv0) + (pe_cnt - pe0) + (se_cnt - se0)), 32'd0);
    send_frame(8, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0);
    idle(4);
    chk("t6_dv_count", 32'(dv_cyc_q.size() - dv0), 32'd1);
    chk("t6_data", 32'(dv_dat_q[dv0]), 32'hC3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
